// File: rtl/adc_trigger_capture.sv
// -----------------------------------------------------------------------------
// adc_trigger_capture
//   Front end of the UART sender. Generates the ADC conversion clock, writes
//   every ADC sample into a circular buffer, waits for a level/slope trigger
//   (or an auto-trigger after a timeout), freezes one DEPTH-sample frame with
//   PRE_TRIG samples of pre-history and streams it oldest-first over a
//   valid/ready byte interface.
//
// Parameters
//   CLK_DIV   Clk cycles per ADC sample (even, >= 2)
//   ADDR_W    buffer address width, DEPTH = 2**ADDR_W
//   PRE_TRIG  samples kept before the trigger sample (1..DEPTH-2)
//   TIMEOUT   Clk cycles spent waiting for a trigger before auto-trigger (>= 2)
//
// Ports
//   Clk, Reset_n           system clock, asynchronous active-low reset
//   Data[7:0]              ADC sample bus
//   ADC_CLK                ADC conversion clock
//   Arm                    single-cycle capture start, honoured only when idle
//   Trig_level[7:0]        unsigned trigger threshold
//   Trig_slope             0 = rising, 1 = falling
//   Out_data/valid/last    frame byte stream, Out_last marks the final byte
//   Out_ready              consumer accepts the current byte
//   Busy                   high whenever a capture or readout is in progress
//   Triggered              1 = last frame came from a real trigger, 0 = auto
// -----------------------------------------------------------------------------
module adc_trigger_capture #(
    parameter int CLK_DIV  = 4,
    parameter int ADDR_W   = 8,
    parameter int PRE_TRIG = 32,
    parameter int TIMEOUT  = 50_000_000
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [7:0]        Data,
    output logic              ADC_CLK,
    input  logic              Arm,
    input  logic [7:0]        Trig_level,
    input  logic              Trig_slope,
    output logic [7:0]        Out_data,
    output logic              Out_valid,
    input  logic              Out_ready,
    output logic              Out_last,
    output logic              Busy,
    output logic              Triggered
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int TO_W  = $clog2(TIMEOUT);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(CLK_DIV / 2);
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
    localparam logic [ADDR_W-1:0] A_ONE     = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
    localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(DEPTH - PRE_TRIG - 2);
    localparam logic [ADDR_W-1:0] CNT_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0]   TO_ONE    = TO_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_READ  = 3'd4
    } state_t;

    // Level/slope crossing between two consecutive samples.
    function automatic logic trig_hit(input logic [7:0] prev, input logic [7:0] cur,
                                      input logic [7:0] lvl, input logic falling);
        logic hit;
        if (falling) begin
            hit = (prev > lvl) && (cur <= lvl);
        end else begin
            hit = (prev < lvl) && (cur >= lvl);
        end
        return hit;
    endfunction

    state_t              state_r;
    state_t              state_nxt_s;
    logic [DIV_W-1:0]    div_cnt_r;
    logic                adc_clk_r;
    logic                strobe_s;
    logic [7:0]          prev_r;
    logic [ADDR_W-1:0]   wptr_r;
    logic [ADDR_W-1:0]   rptr_r;
    logic [ADDR_W-1:0]   rd_addr_s;
    logic [ADDR_W-1:0]   cnt_r;
    logic [TO_W-1:0]     to_cnt_r;
    logic [7:0]          rdata_r;
    logic                out_valid_r;
    logic                out_last_r;
    logic                busy_r;
    logic                triggered_r;
    logic                we_s;
    logic                hit_s;
    logic                to_hit_s;
    logic                fire_s;
    logic                last_xfer_s;
    logic [ADDR_W-1:0]   cnt_after_s;
    logic [7:0]          mem [DEPTH];

    assign ADC_CLK   = adc_clk_r;
    assign Out_data  = rdata_r;
    assign Out_valid = out_valid_r;
    assign Out_last  = out_last_r;
    assign Busy      = busy_r;
    assign Triggered = triggered_r;

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_nxt_s = state_r;
        we_s        = 1'b0;
        strobe_s    = (div_cnt_r == DIV_LAST);
        hit_s       = trig_hit(prev_r, Data, Trig_level, Trig_slope);
        to_hit_s    = (to_cnt_r == TO_LAST);
        fire_s      = out_valid_r && Out_ready;
        last_xfer_s = fire_s && (cnt_r == CNT_LAST);
        // rptr always addresses the byte on the output; step ahead on a
        // transfer so the next byte is in the RAM output register one cycle later.
        if (fire_s) begin
            rd_addr_s   = rptr_r + A_ONE;
            cnt_after_s = cnt_r + A_ONE;
        end else begin
            rd_addr_s   = rptr_r;
            cnt_after_s = cnt_r;
        end
        case (state_r)
            ST_IDLE: begin
                if (Arm) begin
                    state_nxt_s = ST_PRE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PRE: begin
                if (strobe_s) begin
                    we_s = 1'b1;
                    if (cnt_r == PRE_LAST) begin
                        state_nxt_s = ST_ARMED;
                    end else begin
                        state_nxt_s = ST_PRE;
                    end
                end else begin
                    state_nxt_s = ST_PRE;
                end
            end
            ST_ARMED: begin
                if (strobe_s) begin
                    we_s = 1'b1;
                    if (hit_s || to_hit_s) begin
                        state_nxt_s = ST_POST;
                    end else begin
                        state_nxt_s = ST_ARMED;
                    end
                end else begin
                    state_nxt_s = ST_ARMED;
                end
            end
            ST_POST: begin
                if (strobe_s) begin
                    we_s = 1'b1;
                    if (cnt_r == POST_LAST) begin
                        state_nxt_s = ST_READ;
                    end else begin
                        state_nxt_s = ST_POST;
                    end
                end else begin
                    state_nxt_s = ST_POST;
                end
            end
            ST_READ: begin
                if (last_xfer_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_READ;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Sample buffer write port; contents are don't-care after reset.
    always_ff @(posedge Clk) begin
        if (we_s) begin
            mem[wptr_r] <= Data;
        end
    end

    // Sample-clock divider, state, counters, pointers and registered outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_cnt_r   <= '0;
            adc_clk_r   <= 1'b0;
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            prev_r      <= 8'd0;
            wptr_r      <= '0;
            rptr_r      <= '0;
            cnt_r       <= '0;
            to_cnt_r    <= '0;
            triggered_r <= 1'b0;
            rdata_r     <= 8'd0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            if (strobe_s) begin
                div_cnt_r <= '0;
            end else begin
                div_cnt_r <= div_cnt_r + DIV_ONE;
            end
            adc_clk_r <= (div_cnt_r < DIV_HALF);
            state_r   <= state_nxt_s;
            busy_r    <= (state_nxt_s != ST_IDLE);

            if (we_s) begin
                wptr_r <= wptr_r + A_ONE;
                prev_r <= Data;
            end

            // cnt_r counts writes in PRE/POST and transfers in READ; it
            // restarts at every state change.
            if (state_nxt_s != state_r) begin
                cnt_r <= '0;
            end else if (we_s || (state_r == ST_READ && fire_s)) begin
                cnt_r <= cnt_r + A_ONE;
            end

            // Timeout counter saturates at TIMEOUT-1 so the force stays pending
            // until the next sample strobe.
            if (state_r != ST_ARMED) begin
                to_cnt_r <= '0;
            end else if (!to_hit_s) begin
                to_cnt_r <= to_cnt_r + TO_ONE;
            end

            // After the final POST write wptr lands on the oldest sample.
            if (state_r == ST_POST && state_nxt_s == ST_READ) begin
                rptr_r <= wptr_r + A_ONE;
            end else if (state_r == ST_READ && fire_s) begin
                rptr_r <= rptr_r + A_ONE;
            end

            if (state_r == ST_IDLE && Arm) begin
                triggered_r <= 1'b0;
            end else if (state_r == ST_ARMED && strobe_s && hit_s) begin
                triggered_r <= 1'b1;
            end

            // No writes happen in READ, so re-reading the same address while
            // stalled keeps Out_data stable.
            if (state_r == ST_READ) begin
                rdata_r <= mem[rd_addr_s];
            end

            if (state_r == ST_READ && !last_xfer_s) begin
                out_valid_r <= 1'b1;
                out_last_r  <= (cnt_after_s == CNT_LAST);
            end else begin
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_trigger_capture.sv
// -----------------------------------------------------------------------------
// tb_adc_trigger_capture
//   Scoreboard bench: each capture pushes its 256 expected {last, data} bytes
//   into a queue; an independent monitor compares every presented byte with
//   the queue head and pops on each transfer.
// -----------------------------------------------------------------------------
module tb_adc_trigger_capture;

    logic        Clk;
    logic        Reset_n;
    logic [7:0]  Data;
    logic        ADC_CLK;
    logic        Arm;
    logic [7:0]  Trig_level;
    logic        Trig_slope;
    logic [7:0]  Out_data;
    logic        Out_valid;
    logic        Out_ready;
    logic        Out_last;
    logic        Busy;
    logic        Triggered;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [8:0]  exp_q[$];
    logic [7:0]  ramp_base = 8'd0;
    logic [7:0]  ramp_step = 8'd0;
    int          ramp_gen  = 0;
    bit          ready_rnd = 1'b0;

    adc_trigger_capture #(
        .CLK_DIV  (4),
        .ADDR_W   (8),
        .PRE_TRIG (32),
        .TIMEOUT  (1000)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Data       (Data),
        .ADC_CLK    (ADC_CLK),
        .Arm        (Arm),
        .Trig_level (Trig_level),
        .Trig_slope (Trig_slope),
        .Out_data   (Out_data),
        .Out_valid  (Out_valid),
        .Out_ready  (Out_ready),
        .Out_last   (Out_last),
        .Busy       (Busy),
        .Triggered  (Triggered)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // ADC model: reload on a new ramp request, otherwise step once per ADC_CLK rise.
    initial begin
        int   last_gen;
        logic adc_prev;
        last_gen = 0;
        adc_prev = 1'b0;
        Data = 8'd0;
        forever begin
            @(posedge Clk);
            #1;
            if (ramp_gen != last_gen) begin
                last_gen = ramp_gen;
                Data = ramp_base;
            end else if (ADC_CLK && !adc_prev) begin
                Data = Data + ramp_step;
            end
            adc_prev = ADC_CLK;
        end
    end

    // Consumer: always ready, or ready about 30% of cycles.
    initial begin
        Out_ready = 1'b1;
        forever begin
            @(posedge Clk);
            #1;
            Out_ready = ready_rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
        end
    end

    // Monitor: every presented byte (stalled or accepted) must match the queue head.
    initial begin
        logic [8:0] dummy;
        forever begin
            @(negedge Clk);
            if (Reset_n && Out_valid) begin
                if (exp_q.size() == 0) begin
                    check("output_without_expectation", int'(Out_valid), 0);
                end else begin
                    check(Out_ready ? "out_data" : "out_data_stalled", int'(Out_data), int'(exp_q[0][7:0]));
                    check(Out_ready ? "out_last" : "out_last_stalled", int'(Out_last), int'(exp_q[0][8]));
                    if (Out_ready) begin
                        dummy = exp_q.pop_front();
                    end
                end
            end
        end
    end

    // One full capture: byte i of the frame is expected to be first + i*step.
    task automatic run_frame(input string tag, input logic [7:0] base, input logic [7:0] step,
                             input logic slope, input logic [7:0] first, input logic trig,
                             input bit rnd, input bit arm_read, input int min_c, input int max_c);
        int         cycles;
        bit         armed_again;
        logic [7:0] v;
        ramp_base  = base;
        ramp_step  = step;
        ramp_gen++;
        Trig_slope = slope;
        ready_rnd  = rnd;
        for (int i = 0; i < 256; i++) begin
            v = first + 8'(i) * step;
            exp_q.push_back({(i == 255), v});
        end
        tick(2);
        Arm = 1'b1;
        tick(1);
        Arm = 1'b0;
        check({tag, "_busy_after_arm"}, int'(Busy), 1);
        cycles = 0;
        armed_again = 1'b0;
        while (Busy && cycles < 20000) begin
            if (arm_read && Out_valid && !armed_again) begin
                Arm = 1'b1;
                armed_again = 1'b1;
            end
            tick(1);
            Arm = 1'b0;
            cycles++;
        end
        check({tag, "_completes_in_budget"}, int'(cycles < 20000), 1);
        if (max_c > 0) begin
            check({tag, "_busy_cycles_in_window"}, int'(cycles >= min_c && cycles <= max_c), 1);
        end
        check({tag, "_bytes_left_over"}, exp_q.size(), 0);
        exp_q.delete();
        check({tag, "_triggered"}, int'(Triggered), int'(trig));
        check({tag, "_valid_after_last"}, int'(Out_valid), 0);
        check({tag, "_last_after_last"}, int'(Out_last), 0);
        ready_rnd = 1'b0;
        tick(5);
        check({tag, "_idle_after_frame"}, int'(Busy), 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_adc_clk"},   int'(ADC_CLK),   0);
        check({tag, "_out_valid"}, int'(Out_valid), 0);
        check({tag, "_out_last"},  int'(Out_last),  0);
        check({tag, "_out_data"},  int'(Out_data),  0);
        check({tag, "_busy"},      int'(Busy),      0);
        check({tag, "_triggered"}, int'(Triggered), 0);
    endtask

    initial begin
        Reset_n    = 1'b0;
        Arm        = 1'b0;
        Trig_level = 8'd100;
        Trig_slope = 1'b0;
        tick(3);
        check_reset_values("reset");
        Reset_n = 1'b1;
        tick(4);

        // Rising ramp through 100: frame is 68, 69, ... (byte 32 = 100).
        run_frame("rising", 8'd0, 8'd1, 1'b0, 8'd68, 1'b1, 1'b0, 1'b0, 0, 0);
        // Falling ramp through 100: frame is 132, 131, ... (byte 32 = 100).
        run_frame("falling", 8'd255, 8'd255, 1'b1, 8'd132, 1'b1, 1'b0, 1'b0, 0, 0);
        // Constant 50 never crosses 100: auto-trigger after 1000 cycles armed.
        // Busy spans ~128 (PRE) + 1000 (ARMED) + 892 (POST) + 257 (READ) cycles.
        run_frame("auto", 8'd50, 8'd0, 1'b0, 8'd50, 1'b0, 1'b0, 1'b0, 2260, 2290);
        // Consumer stalls randomly.
        run_frame("stall", 8'd0, 8'd1, 1'b0, 8'd68, 1'b1, 1'b1, 1'b0, 0, 0);

        // Reset in the middle of POST discards the partial frame.
        ramp_base  = 8'd0;
        ramp_step  = 8'd1;
        ramp_gen++;
        Trig_slope = 1'b0;
        tick(2);
        Arm = 1'b1;
        tick(1);
        Arm = 1'b0;
        tick(700);
        check("mid_post_busy", int'(Busy), 1);
        Reset_n = 1'b0;
        tick(2);
        check_reset_values("mid_post_reset");
        Reset_n = 1'b1;
        tick(4);
        run_frame("after_reset", 8'd0, 8'd1, 1'b0, 8'd68, 1'b1, 1'b0, 1'b0, 0, 0);

        // Arm during READ must be ignored.
        run_frame("arm_in_read", 8'd0, 8'd1, 1'b0, 8'd68, 1'b1, 1'b0, 1'b1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
